// File: rtl/aes_input_packer.sv
// Byte-serial front end for a fixed-latency AES core: packs 16 plaintext bytes into a block,
// holds block and key stable while the core runs, then captures and hands off the ciphertext.
module aes_input_packer #(
  parameter int unsigned CIPHER_LATENCY = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_ignored,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [127:0] cipher_in,
  output logic [127:0] cipher_key,
  input  logic [127:0] cipher_out,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [7:0] LatLast = 8'(CIPHER_LATENCY - 1);

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StHold
  } state_e;

  state_e         state_q;
  logic [3:0]     byte_cnt_q;
  logic [7:0]     lat_q;
  logic [127:0]   buf_q;
  logic [127:0]   cipher_in_q;
  logic [127:0]   cipher_key_q;
  logic [127:0]   out_data_q;
  logic           out_valid_q;
  logic           key_ignored_q;
  logic           in_ready_q;
  logic           busy_q;

  logic [127:0]   fill_buf;
  logic           byte_acc;
  logic           last_byte;

  // Byte k lands in the AES-ordered slot [127-8k -: 8]; the 16th byte is merged here so the
  // completed block can be launched on the same edge it arrives.
  always_comb begin
    fill_buf = buf_q;
    for (int i = 0; i < 16; i++) begin
      if (byte_cnt_q == 4'(i)) begin
        fill_buf[127-8*i -: 8] = in_data;
      end
    end
  end

  assign byte_acc  = in_valid && in_ready_q && (state_q == StFill);
  assign last_byte = byte_acc && (byte_cnt_q == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFill;
      byte_cnt_q    <= 4'd0;
      lat_q         <= 8'd0;
      buf_q         <= '0;
      cipher_in_q   <= '0;
      cipher_key_q  <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      key_ignored_q <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      key_ignored_q <= 1'b0;
      // The key must not move under a running block; loads are refused only in RUN.
      if (key_load) begin
        if (state_q == StRun) begin
          key_ignored_q <= 1'b1;
        end else begin
          cipher_key_q <= key_in;
        end
      end

      unique case (state_q)
        StFill: begin
          in_ready_q <= 1'b1;
          if (byte_acc) begin
            buf_q      <= fill_buf;
            byte_cnt_q <= byte_cnt_q + 4'd1;
          end
          if (last_byte) begin
            cipher_in_q <= fill_buf;
            lat_q       <= 8'd0;
            state_q     <= StRun;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StRun: begin
          lat_q <= lat_q + 8'd1;
          if (lat_q == LatLast) begin
            out_data_q  <= cipher_out;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StFill;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q    <= StFill;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign key_ignored = key_ignored_q;
  assign in_ready    = in_ready_q;
  assign cipher_in   = cipher_in_q;
  assign cipher_key  = cipher_key_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_aes_input_packer.sv
// Directed bench for aes_input_packer with a lookup stand-in for the AES core
// (returns the FIPS-197 ciphertext for the known plaintext/key pair).
module tb_aes_input_packer;

  localparam int L = 12;
  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2 = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
  localparam logic [127:0] KFF  = {128{1'b1}};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ignored;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [127:0] cipher_in;
  logic [127:0] cipher_key;
  logic [127:0] cipher_out;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic         busy;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int run_entries = 0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  assign cipher_out = (cipher_in == PT && cipher_key == KEY) ? CT : (cipher_in ^ cipher_key);

  aes_input_packer #(.CIPHER_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key_in     (key_in),
    .key_ignored(key_ignored),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cipher_in  (cipher_in),
    .cipher_key (cipher_key),
    .cipher_out (cipher_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (busy && !busy_prev) run_entries++;
    busy_prev = busy;
  endtask

  task automatic send_block(input logic gapped, input logic key_last, input logic [127:0] blk,
                            output logic early_busy);
    int idx;
    int guard;
    logic rdy;
    idx = 0;
    guard = 0;
    early_busy = 1'b0;
    while (idx < 16 && guard < 400) begin
      in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = blk[127-8*idx -: 8];
      key_load = key_last && in_valid && (idx == 15);
      key_in   = KEY;
      rdy      = in_ready;
      step();
      if (in_valid && rdy) idx++;
      if (idx < 16 && busy) early_busy = 1'b1;
      key_load = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    chk("bytes_accepted", 128'(idx), 128'd16);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    int r0;
    logic eb;
    logic bad;
    logic ov;

    rst_n = 1'b0;
    key_load = 1'b0;
    key_in = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_key_ignored", 128'(key_ignored), 128'd0);
    chk("rst_cipher_in", cipher_in, '0);
    chk("rst_cipher_key", cipher_key, '0);
    chk("rst_out_data", out_data, '0);

    rst_n = 1'b1;
    chk("in_ready_before_edge", 128'(in_ready), 128'd0);
    step();
    chk("in_ready_first_edge", 128'(in_ready), 128'd1);

    // Key load in FILL, then FIPS-197 block
    key_load = 1'b1;
    key_in = KEY;
    step();
    key_load = 1'b0;
    chk("key_fill_load", cipher_key, KEY);
    send_block(1'b0, 1'b0, PT, eb);
    chk("run_busy", 128'(busy), 128'd1);
    chk("run_in_ready", 128'(in_ready), 128'd0);
    chk("run_cipher_in", cipher_in, PT);
    wait_valid(n);
    chk("latency", 128'(n), 128'(L));
    chk("fips_ct", out_data, CT);
    t1 = cyc;
    step();
    chk("hs_out_valid", 128'(out_valid), 128'd0);
    chk("hs_in_ready", 128'(in_ready), 128'd1);
    chk("hs_busy", 128'(busy), 128'd0);

    // Back-to-back second block
    send_block(1'b0, 1'b0, PT, eb);
    wait_valid(n);
    t2 = cyc;
    chk("b2b_spacing", 128'(t2 - t1), 128'(16 + L + 1));
    chk("b2b_ct", out_data, CT);

    // Backpressure on second block, with a key load in HOLD
    out_ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      key_load = (i == 10);
      key_in = KEY2;
      step();
      key_load = 1'b0;
      if (out_valid !== 1'b1 || out_data !== CT || in_ready !== 1'b0) bad = 1'b1;
    end
    chk("hold_stable", 128'(bad), 128'd0);
    chk("key_hold_load", cipher_key, KEY2);
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);

    // Key load on the 16th byte, then an ignored load in the 3rd RUN cycle
    send_block(1'b0, 1'b1, PT, eb);
    chk("key_on_last_byte", cipher_key, KEY);
    step();
    step();
    key_load = 1'b1;
    key_in = KFF;
    step();
    key_load = 1'b0;
    chk("key_ignored_pulse", 128'(key_ignored), 128'd1);
    chk("key_run_unchanged", cipher_key, KEY);
    step();
    chk("key_ignored_single", 128'(key_ignored), 128'd0);
    wait_valid(n);
    chk("key_run_latency", 128'(n), 128'(L - 4));
    chk("key_run_ct", out_data, CT);
    step();

    // Gapped input
    r0 = run_entries;
    send_block(1'b1, 1'b0, PT, eb);
    chk("gap_cipher_in", cipher_in, PT);
    chk("gap_no_early_run", 128'(eb), 128'd0);
    wait_valid(n);
    chk("gap_ct", out_data, CT);
    chk("gap_run_once", 128'(run_entries - r0), 128'd1);
    step();

    // Reset at latency count 5
    send_block(1'b0, 1'b0, PT, eb);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    step();
    chk("mrst_out_valid", 128'(out_valid), 128'd0);
    chk("mrst_busy", 128'(busy), 128'd0);
    chk("mrst_in_ready", 128'(in_ready), 128'd0);
    chk("mrst_cipher_in", cipher_in, '0);
    chk("mrst_cipher_key", cipher_key, '0);
    chk("mrst_out_data", out_data, '0);
    rst_n = 1'b1;
    ov = 1'b0;
    repeat (L + 5) begin
      step();
      if (out_valid) ov = 1'b1;
    end
    chk("mrst_no_out_valid", 128'(ov), 128'd0);

    // Reset mid-FILL discards partial bytes
    in_valid = 1'b1;
    in_data = 8'hee;
    repeat (5) step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    key_load = 1'b1;
    key_in = KEY;
    step();
    key_load = 1'b0;
    send_block(1'b0, 1'b0, PT, eb);
    chk("refill_cipher_in", cipher_in, PT);
    wait_valid(n);
    chk("refill_latency", 128'(n), 128'(L));
    chk("refill_ct", out_data, CT);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
